// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Arbitrates a single-port synchronous instruction memory between the core's
// fetch port and a program loader.
//
// LOAD (entered from reset): only the loader may write. Fetches are held off,
// and load_ready follows load_req. A load_done pulse moves the block to RUN;
// a write accepted in that same cycle still completes.
//
// RUN (left only by reset): fetch has priority. The loader is granted when
// there is no fetch request, or when it has been denied STARVE_MAX
// consecutive cycles. In that case the fetch is stalled for one cycle.
//
// Read data arrives one cycle after a fetch grant. It is presented on
// fetch_instr together with fetch_valid, and it is held until the next valid
// fetch.
//
// Optional feature: define IMEM_ALIGN_CHECK_EN to enable a sticky
// misaligned-fetch flag (fetch_misalign). Without the macro the flag is tied
// low.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   fetch_req/addr      core fetch request, byte address
//   fetch_ready         fetch granted this cycle (combinational)
//   fetch_valid/instr   returned instruction, one cycle after the grant
//   load_req/addr/data  loader write request, byte address, write data
//   load_ready          write granted this cycle (combinational)
//   load_done           one-cycle pulse marking the end of the program image
//   mem_en/we/addr/wdata/rdata  memory port (word address, 1-cycle read)
//   core_run            high in RUN; releases the core
//   fetch_misalign      sticky misaligned-fetch flag
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,

  input  logic              load_req,
  input  logic [31:0]       load_addr,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  input  logic              load_done,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,

  output logic              core_run,
  output logic              fetch_misalign
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic              fetch_gnt, load_gnt, forced;
  logic [31:0]       instr_hold;
  logic [ADDR_W-1:0] fetch_word, load_word;

  // Word addresses. The bits above the memory size are dropped, so accesses
  // wrap. The byte-offset bits are dropped as well.
  assign fetch_word = fetch_addr[ADDR_W+1:2];
  assign load_word  = load_addr[ADDR_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0],
                              load_addr[31:ADDR_W+2], load_addr[1:0]};

  // Next state and grants
  always_comb begin
    state_nxt = state;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    forced    = 1'b0;
    unique case (state)
      ST_LOAD: begin
        load_gnt = load_req;
        if (load_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        forced    = load_req && (starve_cnt >= CNT_MAX);
        fetch_gnt = fetch_req && !forced;
        load_gnt  = load_req && !fetch_gnt;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // The counter only advances on a denied loader cycle in RUN. Any grant,
  // an idle loader, or LOAD brings it back to zero.
  always_comb begin
    starve_nxt = '0;
    if (state == ST_RUN && load_req && !load_gnt) begin
      starve_nxt = (starve_cnt >= CNT_MAX) ? CNT_MAX : starve_cnt + CNT_W'(1);
    end
  end

  // Memory port and grant indications
  always_comb begin
    fetch_ready = fetch_gnt;
    load_ready  = load_gnt;
    mem_en      = fetch_gnt || load_gnt;
    mem_we      = load_gnt;
    mem_addr    = load_gnt ? load_word : fetch_word;
    mem_wdata   = load_gnt ? load_data : '0;
  end

  assign core_run = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      starve_cnt  <= '0;
      fetch_valid <= 1'b0;
      instr_hold  <= NOP;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= starve_nxt;
      fetch_valid <= fetch_gnt;
      if (fetch_valid) instr_hold <= mem_rdata;
    end
  end

  // Read data is passed straight through in its valid cycle. Outside that
  // cycle the last delivered word is held.
  assign fetch_instr = fetch_valid ? mem_rdata : instr_hold;

`ifdef IMEM_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (fetch_gnt && (fetch_addr[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign fetch_misalign = misalign_q;
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Drives imem_arbiter with directed and random cycles. A behavioural model
// tracks the mode, the loader wait count, the memory image and the pending
// fetch. It predicts the grants, the memory port and the returned
// instructions.
//
// A simple synchronous RAM stands in for the instruction memory.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready, fetch_valid;
  logic [31:0]       fetch_instr;
  logic              load_req;
  logic [31:0]       load_addr, load_data;
  logic              load_ready, load_done;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              core_run, fetch_misalign;

  imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_run(core_run), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  // Instruction memory: a synchronous RAM with one-cycle read latency.
  logic [31:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural reference state
  bit          m_run;
  int          m_starve;
  logic [31:0] m_mem [DEPTH];
  bit          m_pend;
  logic [31:0] m_pend_data;
  logic [31:0] m_last;
  bit          m_mis;

  // Values observed in the most recent step
  logic obs_fr, obs_lr, obs_fv, obs_run, obs_mis;
  logic [31:0] obs_fi;

  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  task automatic model_reset();
    m_run = 0; m_starve = 0; m_pend = 0; m_last = NOP; m_mis = 0;
  endtask

  // One clock cycle. Inputs are driven at the negedge. The outputs are checked
  // 1 ns later, and the model advances at the following posedge.
  task automatic step(input bit fr, input logic [31:0] fa, input bit lr,
                      input logic [31:0] la, input logic [31:0] ld, input bit ldn);
    bit e_f, e_l;
    fetch_req = fr; fetch_addr = fa; load_req = lr; load_addr = la;
    load_data = ld; load_done = ldn;
    #1;
    if (!m_run) begin
      e_f = 0;
      e_l = lr;
    end else begin
      e_l = lr && (!fr || m_starve >= STARVE_MAX);
      e_f = fr && !e_l;
    end
    check_eq("fetch_ready", 32'(fetch_ready), 32'(e_f));
    check_eq("load_ready", 32'(load_ready), 32'(e_l));
    check_eq("mem_en", 32'(mem_en), 32'(e_f || e_l));
    check_eq("mem_we", 32'(mem_we), 32'(e_l));
    if (e_f) check_eq("mem_addr_fetch", 32'(mem_addr), widx(fa));
    if (e_l) begin
      check_eq("mem_addr_load", 32'(mem_addr), widx(la));
      check_eq("mem_wdata", mem_wdata, ld);
    end
    check_eq("fetch_valid", 32'(fetch_valid), 32'(m_pend));
    check_eq("fetch_instr", fetch_instr, m_pend ? m_pend_data : m_last);
    check_eq("core_run", 32'(core_run), 32'(m_run));
    check_eq("fetch_misalign", 32'(fetch_misalign), 32'(m_mis));
    obs_fr = fetch_ready; obs_lr = load_ready; obs_fv = fetch_valid;
    obs_fi = fetch_instr; obs_run = core_run; obs_mis = fetch_misalign;
    @(posedge clk);
    if (m_pend) m_last = m_pend_data;
    m_pend = e_f;
    if (e_f) m_pend_data = m_mem[widx(fa)];
    if (e_l) m_mem[widx(la)] = ld;
    if (m_run) begin
      if (lr && !e_l) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else            m_starve = 0;
    end else if (ldn) begin
      m_run = 1;
    end
`ifdef IMEM_ALIGN_CHECK_EN
    if (e_f && fa[1:0] != 2'b00) m_mis = 1;
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, '0, 0, '0, '0, 0);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    fetch_req = 0; fetch_addr = '0; load_req = 0; load_addr = '0;
    load_data = '0; load_done = 0;
    #1;
    check_eq("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check_eq("rst_fetch_instr", fetch_instr, NOP);
    check_eq("rst_core_run", 32'(core_run), 32'd0);
    check_eq("rst_misalign", 32'(fetch_misalign), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    int first;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // LOAD: the fetch request is held high and must never be granted.
    // Only the loader writes.
    for (int i = 0; i < 10; i++) begin
      if (i == 2)      step(1, 32'h0, 1, 32'h0, 32'h0000_0093, 0);
      else if (i == 5) step(1, 32'h0, 1, 32'h4, 32'h0010_0113, 0);
      else if (i == 7) step(1, 32'h0, 1, 32'h20, $urandom, 0);
      else             step(1, 32'h0, 0, '0, '0, 0);
      check_eq("load_no_fetch", 32'(obs_fr), 32'd0);
    end
    // A write accepted together with load_done still lands.
    step(0, '0, 1, 32'h8, 32'hCAFE_0001, 1);
    check_eq("done_cycle_run", 32'(obs_run), 32'd0);
    idle();
    check_eq("run_after_done", 32'(obs_run), 32'd1);

    // Back-to-back fetches return one word per cycle.
    step(1, 32'h0, 0, '0, '0, 0);
    step(1, 32'h4, 0, '0, '0, 0);
    check_eq("b2b_valid0", 32'(obs_fv), 32'd1);
    check_eq("b2b_instr0", obs_fi, 32'h0000_0093);
    step(1, 32'h8, 0, '0, '0, 0);
    check_eq("b2b_valid1", 32'(obs_fv), 32'd1);
    check_eq("b2b_instr1", obs_fi, 32'h0010_0113);
    idle();
    check_eq("done_write", obs_fi, 32'hCAFE_0001);
    idle();
    check_eq("hold_instr", obs_fi, 32'hCAFE_0001);

    // The loader is starved by continuous fetching until a grant is forced.
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1, 32'h0, 1, 32'h40, 32'h1111_0000 + 32'(i), 0);
      if (obs_lr && first == 0) begin
        first = i;
        check_eq("forced_no_fetch", 32'(obs_fr), 32'd0);
      end
    end
    check_eq("starve_grant_cycle", 32'(first), 32'(STARVE_MAX + 1));
    for (int i = 0; i < 6; i++) step(1, 32'h4, 1, 32'h44, $urandom, 0);
    idle();

    // Addresses wrap at the memory size.
    step(1, 32'h400, 0, '0, '0, 0);
    idle();
    check_eq("wrap_instr", obs_fi, 32'h0000_0093);

    // A misaligned fetch reads the enclosing word.
    step(1, 32'h6, 0, '0, '0, 0);
    idle();
    check_eq("misalign_data", obs_fi, 32'h0010_0113);
    idle();
`ifdef IMEM_ALIGN_CHECK_EN
    check_eq("misalign_flag", 32'(obs_mis), 32'd1);
`else
    check_eq("misalign_flag", 32'(obs_mis), 32'd0);
`endif

    // Random traffic in RUN. load_done must have no effect here.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
           $urandom, $urandom, $urandom_range(0, 7) == 0);
    end
    idle();

    // A reset in the cycle after a fetch grant drops the pending fetch.
    step(1, 32'h4, 0, '0, '0, 0);
    apply_reset();
    idle();
    check_eq("post_rst_valid", 32'(obs_fv), 32'd0);
    check_eq("post_rst_instr", obs_fi, NOP);
    for (int i = 0; i < 4; i++) step(1, 32'h4, 0, '0, '0, 0);

    // Random traffic in the second LOAD phase, then RUN again.
    for (int i = 0; i < 30; i++) begin
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
           $urandom, $urandom, 0);
    end
    step(0, '0, 0, '0, '0, 1);
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0,
           $urandom, $urandom, 0);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
